fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter: WIDTH, default 3, data width of each requester word and of the shared FIFO.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester enqueue request; bit i belongs to requester i.
REQ-005 Port: req_data  input  4*WIDTH  requester words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 Port: fifo_full  input  1  shared FIFO full flag.
REQ-007 Port: fifo_afull  input  1  shared FIFO has exactly one free slot.
REQ-008 Port: grant  output  4  registered one-hot acknowledge; grant[i]=1 means requester i's word was written to the FIFO at the preceding edge.
REQ-009 Port: fifo_enqueue  output  1  registered enqueue strobe to the FIFO.
REQ-010 Port: fifo_q_in  output  WIDTH  registered data to the FIFO.
REQ-011 Port: grant_cnt  output  8  total accepted writes; present only with ARB_GRANT_CNT_EN.

Function
REQ-012 Eligible set each cycle SHALL be req & ~grant: the requester currently being acknowledged is masked for that cycle.
REQ-013 Issue condition SHALL be: eligible set non-zero AND fifo_full=0 AND NOT (fifo_enqueue=1 AND fifo_afull=1).
REQ-014 Winner SHALL be the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo 4 (2-bit rr_ptr, wraps 3->0).
REQ-015 On an edge where the issue condition holds: grant <= one-hot(winner), fifo_enqueue <= 1, fifo_q_in <= req_data word of winner, rr_ptr <= winner+1 mod 4.
REQ-016 On an edge where the issue condition fails: grant <= 0, fifo_enqueue <= 0, fifo_q_in holds, rr_ptr holds.
REQ-017 Latency SHALL be one cycle from sampled req to grant/fifo_enqueue; grant and fifo_enqueue are always asserted together.
REQ-018 Requester contract: on seeing grant[i]=1, requester i SHALL deassert req[i] or present its next word in that same cycle.
REQ-019 Throughput SHALL be one write per cycle across different requesters and one write per two cycles for a single requester.
REQ-020 Deasserting req[i] before the edge withdraws the request with no side effect; the words of requesters that are not granted are never consumed.
REQ-021 With fifo_full=1 no write SHALL issue, whatever the value of req.
REQ-022 The afull rule of REQ-013 SHALL guarantee no overflow despite the one-cycle registered enqueue.

Reset
REQ-023 Asserting reset SHALL immediately, without waiting for a clock edge, force grant=0, fifo_enqueue=0, fifo_q_in=0, rr_ptr=0, grant_cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight decision; the first edge after release arbitrates with requester 0 as highest priority.

Configuration
REQ-025 Macro ARB_GRANT_CNT_EN: when defined, grant_cnt increments on every edge that sets fifo_enqueue=1 and saturates at 255.
REQ-026 With ARB_GRANT_CNT_EN undefined, the grant_cnt port and its register SHALL be absent; all other behaviour is unchanged.

Verification
REQ-027 Round-robin: WIDTH=3; req=1111; words 1,2,3,4 for requesters 0-3; FIFO never full -> grant 0001,0010,0100,1000 on consecutive cycles; fifo_q_in 1,2,3,4; fifo_enqueue high for 4 cycles.
REQ-028 Single requester: only req[2]=1 held, with a new word each time it is granted -> grant alternates 0100,0000; fifo_enqueue high every other cycle.
REQ-029 Full stall and resume: fifo_full=1 for 5 cycles with req=0011 -> grant=0 and fifo_enqueue=0 throughout; after fifo_full drops -> requester 0 is granted, then requester 1 on the next cycle.
REQ-030 Afull bubble: fifo_enqueue=1 and fifo_afull=1 with req=0110 -> next cycle grant=0000; requester 2 is granted the following cycle once fifo_afull=0.
REQ-031 Async reset: assert reset between edges while grant=1000 -> grant, fifo_enqueue and fifo_q_in read 0 before the next edge; after release with req=1001 -> first grant=0001.
REQ-032 ARB_GRANT_CNT_EN defined: 300 accepted writes -> grant_cnt reads 255 and holds at 255.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Four-requester round-robin write arbiter feeding one shared FIFO, with full/afull backpressure.
// Optional saturating accepted-write counter on grant_cnt when ARB_GRANT_CNT_EN is defined.
module fifo_write_arbiter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_data,
  input  logic               fifo_full,
  input  logic               fifo_afull,
  output logic [3:0]         grant,
  output logic               fifo_enqueue,
`ifdef ARB_GRANT_CNT_EN
  output logic [7:0]         grant_cnt,
`endif
  output logic [WIDTH-1:0]   fifo_q_in
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CNT_W = 8;

  logic [3:0]       r_grant;
  logic             r_enq;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       r_rr_ptr;

  logic [3:0]       w_elig;
  logic             w_issue;
  logic [1:0]       w_win;
  logic             w_found;
  logic [WIDTH-1:0] w_words [N_REQ];

  // Slice the flat requester bus into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_words[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // A registered enqueue already claims the last free slot when afull is up
  assign w_elig  = req & ~r_grant;
  assign w_issue = (|w_elig) && !fifo_full && !(r_enq && fifo_afull);

  // First eligible requester scanning upward from the round-robin pointer
  always_comb begin
    logic [1:0] idx;
    w_win   = r_rr_ptr;
    w_found = 1'b0;
    idx     = r_rr_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = r_rr_ptr + 2'(k);
      if (!w_found && w_elig[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant  <= 4'b0000;
      r_enq    <= 1'b0;
      r_q      <= '0;
      r_rr_ptr <= 2'd0;
    end else if (w_issue) begin
      r_grant  <= 4'b0001 << w_win;
      r_enq    <= 1'b1;
      r_q      <= w_words[w_win];
      r_rr_ptr <= w_win + 2'd1;
    end else begin
      r_grant  <= 4'b0000;
      r_enq    <= 1'b0;
    end
  end

  assign grant        = r_grant;
  assign fifo_enqueue = r_enq;
  assign fifo_q_in    = r_q;

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of accepted writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_issue && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios push expected grant/enqueue/data per cycle.
// Define ARB_GRANT_CNT_EN for both files to also exercise the saturating grant counter.
module tb_fifo_write_arbiter;

  localparam int unsigned WIDTH = 3;

  logic               clock;
  logic               reset;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] req_data;
  logic               fifo_full;
  logic               fifo_afull;
  logic [3:0]         grant;
  logic               fifo_enqueue;
  logic [WIDTH-1:0]   fifo_q_in;
`ifdef ARB_GRANT_CNT_EN
  logic [7:0]         grant_cnt;
`endif

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_step;

  logic [7:0] sb_q [$];

  fifo_write_arbiter #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .grant        (grant),
    .fifo_enqueue (fifo_enqueue),
`ifdef ARB_GRANT_CNT_EN
    .grant_cnt    (grant_cnt),
`endif
    .fifo_q_in    (fifo_q_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] words(input logic [2:0] w3, input logic [2:0] w2,
                                         input logic [2:0] w1, input logic [2:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  // Drive one cycle of inputs, queue what must appear after the edge, then score it
  task automatic step(input logic [3:0] r, input logic [11:0] d, input logic f, input logic af,
                      input logic [3:0] eg, input logic ee, input logic [2:0] eq);
    logic [7:0] e;
    req        = r;
    req_data   = d;
    fifo_full  = f;
    fifo_afull = af;
    sb_q.push_back({eg, ee, eq});
    @(posedge clock);
    #1;
    n_step++;
    e = sb_q.pop_front();
    chk($sformatf("s%0d grant", n_step), 32'(grant), 32'(e[7:4]));
    chk($sformatf("s%0d enq", n_step), 32'(fifo_enqueue), 32'(e[3]));
    chk($sformatf("s%0d q_in", n_step), 32'(fifo_q_in), 32'(e[2:0]));
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_step = 0;
    req = 4'b0000; req_data = '0; fifo_full = 1'b0; fifo_afull = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst enq", 32'(fifo_enqueue), 32'h0);
    chk("rst q_in", 32'(fifo_q_in), 32'h0);
`ifdef ARB_GRANT_CNT_EN
    chk("rst cnt", 32'(grant_cnt), 32'h0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;

    // Round-robin across all four requesters
    step(4'b1111, words(3'd4, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0001, 1'b1, 3'd1);
    step(4'b1111, words(3'd4, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0010, 1'b1, 3'd2);
    step(4'b1111, words(3'd4, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0100, 1'b1, 3'd3);
    step(4'b1111, words(3'd4, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 4'b1000, 1'b1, 3'd4);
    step(4'b0000, words(3'd4, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd4);

    // Single requester 2: one write per two cycles, new word after each grant
    step(4'b0100, words(3'd0, 3'd5, 3'd0, 3'd0), 1'b0, 1'b0, 4'b0100, 1'b1, 3'd5);
    step(4'b0100, words(3'd0, 3'd6, 3'd0, 3'd0), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd5);
    step(4'b0100, words(3'd0, 3'd6, 3'd0, 3'd0), 1'b0, 1'b0, 4'b0100, 1'b1, 3'd6);
    step(4'b0100, words(3'd0, 3'd7, 3'd0, 3'd0), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd6);
    step(4'b0100, words(3'd0, 3'd7, 3'd0, 3'd0), 1'b0, 1'b0, 4'b0100, 1'b1, 3'd7);
    step(4'b0000, words(3'd0, 3'd7, 3'd0, 3'd0), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd7);

    // Full stall for five cycles, then resume with requester 0 then 1
    for (int i = 0; i < 5; i++)
      step(4'b0011, words(3'd0, 3'd0, 3'd2, 3'd1), 1'b1, 1'b0, 4'b0000, 1'b0, 3'd7);
    step(4'b0011, words(3'd0, 3'd0, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0001, 1'b1, 3'd1);
    step(4'b0011, words(3'd0, 3'd0, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0010, 1'b1, 3'd2);
    step(4'b0000, words(3'd0, 3'd0, 3'd2, 3'd1), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2);

    // Afull bubble after a registered enqueue, then requester 2 wins
    step(4'b0010, words(3'd0, 3'd3, 3'd5, 3'd0), 1'b0, 1'b0, 4'b0010, 1'b1, 3'd5);
    step(4'b0110, words(3'd0, 3'd3, 3'd5, 3'd0), 1'b0, 1'b1, 4'b0000, 1'b0, 3'd5);
    step(4'b0110, words(3'd0, 3'd3, 3'd5, 3'd0), 1'b0, 1'b0, 4'b0100, 1'b1, 3'd3);
    step(4'b0000, words(3'd0, 3'd3, 3'd5, 3'd0), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd3);
    // Afull alone, with no enqueue pending, does not block
    step(4'b0001, words(3'd0, 3'd0, 3'd0, 3'd4), 1'b0, 1'b1, 4'b0001, 1'b1, 3'd4);
    step(4'b0000, words(3'd0, 3'd0, 3'd0, 3'd4), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd4);

    // Asynchronous reset while requester 3 holds the grant
    step(4'b1000, words(3'd6, 3'd0, 3'd0, 3'd0), 1'b0, 1'b0, 4'b1000, 1'b1, 3'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("async grant", 32'(grant), 32'h0);
    chk("async enq", 32'(fifo_enqueue), 32'h0);
    chk("async q_in", 32'(fifo_q_in), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    step(4'b1001, words(3'd6, 3'd0, 3'd0, 3'd3), 1'b0, 1'b0, 4'b0001, 1'b1, 3'd3);
    step(4'b1000, words(3'd6, 3'd0, 3'd0, 3'd3), 1'b0, 1'b0, 4'b1000, 1'b1, 3'd6);
    step(4'b0000, words(3'd6, 3'd0, 3'd0, 3'd3), 1'b0, 1'b0, 4'b0000, 1'b0, 3'd6);

`ifdef ARB_GRANT_CNT_EN
    // 300 accepted writes alternating requesters 0 and 1; counter saturates
    req = 4'b0011; req_data = words(3'd0, 3'd0, 3'd2, 3'd1);
    fifo_full = 1'b0; fifo_afull = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
    end
    chk("cnt sat", 32'(grant_cnt), 32'd255);
    req = 4'b0000;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("cnt hold", 32'(grant_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
